// File: rtl/hazard_scheduler.sv
// -----------------------------------------------------------------------------
// hazard_scheduler
// Hazard controller for the 5-stage (F/D/E/M/W) 24-bit core. A shadow pipeline
// of destination/source tags for E, M and W drives ALU operand forwarding,
// load-use stalls, branch flushes and the data-memory wait freeze.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   valid_d             D holds a real instruction
//   rs1_d, rs2_d        source registers of the instruction in D
//   uses_rs1_d/_rs2_d   the instruction in D reads rs1 / rs2
//   rd_d, regwrite_d    destination register and its write enable
//   memread_d/_memwrite_d  instruction in D is a load / store
//   branch_taken_e      branch in E resolved taken
//   mem_busy            data memory not ready this cycle
//   stall_f, stall_d    hold fetch / decode registers
//   stall_em            hold E and M registers (memory freeze)
//   flush_d, flush_e    clear D / bubble into E
//   forward_a_e/_b_e    operand select: 00 regfile, 01 W result, 10 M ALU result
//   mem_timeout         sticky memory timeout error
// -----------------------------------------------------------------------------
module hazard_scheduler #(
    parameter int REG_AW       = 4,
    parameter int MAX_MEM_WAIT = 15,
    parameter int CNT_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              uses_rs1_d,
    input  logic              uses_rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              regwrite_d,
    input  logic              memread_d,
    input  logic              memwrite_d,
    input  logic              branch_taken_e,
    input  logic              mem_busy,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_em,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              mem_timeout
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use1;
        logic              use2;
    } e_tag_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
    } mw_tag_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_MEM_WAIT);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);

    // Operand select for one E source: M beats W, bubbles and unused sources get the regfile.
    function automatic logic [1:0] fwd_sel(input mw_tag_t m, input mw_tag_t w,
                                           input logic e_valid, input logic use_src,
                                           input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        if (!(e_valid && use_src)) begin
            sel = 2'b00;
        end else if (m.valid && m.regwrite && (m.rd == src)) begin
            sel = 2'b10;
        end else if (w.valid && w.regwrite && (w.rd == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    e_tag_t     e_q, e_d;
    mw_tag_t    m_q, m_d, w_q, w_d;
    state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       init_done_q, init_done_d;

    logic       mem_op_m_s;
    logic       freeze_s;
    logic       load_use_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic       unused_w_mem_s;

    // W only feeds forwarding; its memory bits ride along for completeness.
    assign unused_w_mem_s = w_q.memread | w_q.memwrite;

    assign mem_op_m_s = m_q.valid && (m_q.memread || m_q.memwrite);
    assign cnt_inc_s  = (cnt_q == MAX_C) ? cnt_q : (cnt_q + ONE_C);
    assign load_use_s = e_q.valid && e_q.memread && e_q.regwrite && valid_d &&
                        ((uses_rs1_d && (rs1_d == e_q.rd)) ||
                         (uses_rs2_d && (rs2_d == e_q.rd)));
    assign init_done_d = 1'b1;

    // Memory-wait FSM: next state, wait counter and freeze request.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        freeze_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_busy && mem_op_m_s) begin
                    // Freeze starts in the very cycle the stalled access is seen.
                    freeze_s = 1'b1;
                    cnt_d    = ONE_C;
                    state_d  = (ONE_C == MAX_C) ? ST_TIMEOUT : ST_MEM_WAIT;
                end else begin
                    cnt_d   = ZERO_C;
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    freeze_s = 1'b1;
                    cnt_d    = cnt_inc_s;
                    state_d  = (cnt_inc_s == MAX_C) ? ST_TIMEOUT : ST_MEM_WAIT;
                end else begin
                    cnt_d   = ZERO_C;
                    state_d = ST_RUN;
                end
            end
            ST_TIMEOUT: begin
                freeze_s = 1'b1;
                state_d  = ST_TIMEOUT;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = ZERO_C;
            end
        endcase
    end

    // Stall/flush/forward outputs; freeze beats branch, branch beats load-use.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_em    = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        mem_timeout = (state_q == ST_TIMEOUT);
        if (!init_done_q) begin
            // Quiet during reset and the first cycle after release.
            mem_timeout = 1'b0;
        end else begin
            forward_a_e = fwd_sel(m_q, w_q, e_q.valid, e_q.use1, e_q.rs1);
            forward_b_e = fwd_sel(m_q, w_q, e_q.valid, e_q.use2, e_q.rs2);
            if (freeze_s) begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                stall_em = 1'b1;
            end else if (branch_taken_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use_s) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else begin
                stall_f = 1'b0;
            end
        end
    end

    // Shadow tag advance; nothing moves while frozen.
    always_comb begin
        e_d = e_q;
        m_d = m_q;
        w_d = w_q;
        if (freeze_s) begin
            e_d = e_q;
        end else begin
            if (flush_e || !valid_d) begin
                e_d = e_tag_t'(0);
            end else begin
                e_d.valid    = 1'b1;
                e_d.rd       = rd_d;
                e_d.regwrite = regwrite_d;
                e_d.memread  = memread_d;
                e_d.memwrite = memwrite_d;
                e_d.rs1      = rs1_d;
                e_d.rs2      = rs2_d;
                e_d.use1     = uses_rs1_d;
                e_d.use2     = uses_rs2_d;
            end
            m_d.valid    = e_q.valid;
            m_d.rd       = e_q.rd;
            m_d.regwrite = e_q.regwrite;
            m_d.memread  = e_q.memread;
            m_d.memwrite = e_q.memwrite;
            w_d          = m_q;
        end
    end

    // State, counter and tag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q         <= e_tag_t'(0);
            m_q         <= mw_tag_t'(0);
            w_q         <= mw_tag_t'(0);
            state_q     <= ST_RUN;
            cnt_q       <= ZERO_C;
            init_done_q <= 1'b0;
        end else begin
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

endmodule
